// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control: button debounce, start/stop/lap/clear FSM, 4-digit BCD count
// Buttons are indexed {clr, lap, start}; all outputs are registered from the internal state.
module stopwatch_ctrl #(
    parameter int TICK_DIV        = 120000,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        BTN_START,
    input  logic        BTN_LAP,
    input  logic        BTN_CLR,
    output logic [15:0] display_value,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAP, S_STOP} state_t;

    logic [2:0]         sync1_q, sync1_d, sync2_q, sync2_d, acc_q, acc_d;
    logic [2:0][DW-1:0] db_cnt_q, db_cnt_d;
    logic [2:0]         press;
    state_t             state_q, state_d;
    logic [PW-1:0]      pre_q, pre_d;
    logic [15:0]        count_q, count_d, lap_reg_q, lap_reg_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        display_q, display_d;
    logic               running_q, running_d, lap_active_q, lap_active_d, ovf_out_q, ovf_out_d;
    logic               active, tick;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        sync1_d  = {BTN_CLR, BTN_LAP, BTN_START};
        sync2_d  = sync1_q;
        acc_d    = acc_q;
        db_cnt_d = '0;
        press    = '0;
        // The debounce counter only advances while the synchronised level disagrees with the accepted one.
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != acc_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    acc_d[i] = sync2_q[i];
                    press[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DW'(1);
                end
            end
        end

        active = (state_q == S_RUN) || (state_q == S_LAP);
        tick   = active && (pre_q == PRE_LAST);
        pre_d  = pre_q;
        if (active) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end

        count_d = count_q;
        ovf_d   = ovf_q;
        if (tick) begin
            count_d = bcd_inc(count_q);
            if (count_q == 16'h9999) begin
                ovf_d = 1'b1;
            end
        end

        state_d   = state_q;
        lap_reg_d = lap_reg_q;
        case (state_q)
            S_IDLE: if (press[0]) state_d = S_RUN;
            S_RUN: begin
                if (press[0]) begin
                    state_d = S_STOP;
                end else if (press[1]) begin
                    state_d   = S_LAP;
                    lap_reg_d = count_d;
                end
            end
            S_LAP: begin
                if (press[0])      state_d = S_STOP;
                else if (press[1]) state_d = S_RUN;
            end
            S_STOP: begin
                if (press[2]) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    pre_d   = '0;
                    ovf_d   = 1'b0;
                end else if (press[0]) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        display_d    = (state_q == S_LAP) ? lap_reg_q : count_q;
        running_d    = active;
        lap_active_d = (state_q == S_LAP);
        ovf_out_d    = ovf_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            acc_q        <= '0;
            db_cnt_q     <= '0;
            state_q      <= S_IDLE;
            pre_q        <= '0;
            count_q      <= '0;
            lap_reg_q    <= '0;
            ovf_q        <= 1'b0;
            display_q    <= '0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            ovf_out_q    <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            acc_q        <= acc_d;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            pre_q        <= pre_d;
            count_q      <= count_d;
            lap_reg_q    <= lap_reg_d;
            ovf_q        <= ovf_d;
            display_q    <= display_d;
            running_q    <= running_d;
            lap_active_q <= lap_active_d;
            ovf_out_q    <= ovf_out_d;
        end
    end

    assign display_value = display_q;
    assign running       = running_q;
    assign lap_active    = lap_active_q;
    assign overflow      = ovf_out_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl against an integer-time reference model
module tb_stopwatch_ctrl;
    localparam int TD  = 4;
    localparam int DC  = 3;
    localparam int LAT = 2 + DC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        b_start = 1'b0, b_lap = 1'b0, b_clr = 1'b0;
    logic [15:0] display_value;
    logic        running, lap_active, overflow;

    stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DC)) dut (
        .CLK(clk), .RST_N(rst_n), .BTN_START(b_start), .BTN_LAP(b_lap), .BTN_CLR(b_clr),
        .display_value(display_value), .running(running), .lap_active(lap_active), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: time kept as an integer 0..9999, mode 0=idle 1=run 2=lap 3=stop.
    typedef struct {int c; logic [18:0] v;} exp_t;
    exp_t        sb[$];
    int          q_start[$], q_lap[$], q_clr[$];
    int          cyc = 0;
    int          m_mode = 0, m_cnt = 0, m_lap = 0, m_pre = 0;
    bit          m_ovf = 0;
    logic [15:0] o_disp = '0;
    bit          o_run = 0, o_lap = 0, o_ovf = 0;
    logic [18:0] last_push = '0;
    bit          p_s, p_l, p_c, m_tick;

    function automatic logic [15:0] bcd(input int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic push(input int c);
        logic [18:0] v;
        v = {o_disp, o_run, o_lap, o_ovf};
        if (v != last_push) begin
            sb.push_back('{c, v});
            last_push = v;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (clk) cyc++;
            m_mode = 0; m_cnt = 0; m_lap = 0; m_pre = 0; m_ovf = 0;
            o_disp = '0; o_run = 0; o_lap = 0; o_ovf = 0;
            q_start.delete(); q_lap.delete(); q_clr.delete();
            push(clk ? cyc : cyc + 1);
        end else begin
            cyc++;
            o_disp = (m_mode == 2) ? bcd(m_lap) : bcd(m_cnt);
            o_run  = (m_mode == 1) || (m_mode == 2);
            o_lap  = (m_mode == 2);
            o_ovf  = m_ovf;
            p_s = (q_start.size() > 0) && (q_start[0] == cyc);
            p_l = (q_lap.size() > 0) && (q_lap[0] == cyc);
            p_c = (q_clr.size() > 0) && (q_clr[0] == cyc);
            if (p_s) void'(q_start.pop_front());
            if (p_l) void'(q_lap.pop_front());
            if (p_c) void'(q_clr.pop_front());
            m_tick = 0;
            if (o_run) begin
                m_tick = (m_pre == TD - 1);
                m_pre  = (m_pre + 1) % TD;
            end
            if (m_tick) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == 10000) begin
                    m_cnt = 0;
                    m_ovf = 1;
                end
            end
            case (m_mode)
                0: if (p_s) m_mode = 1;
                1: if (p_s) m_mode = 3; else if (p_l) begin m_mode = 2; m_lap = m_cnt; end
                2: if (p_s) m_mode = 3; else if (p_l) m_mode = 1;
                default: if (p_c) begin m_mode = 0; m_cnt = 0; m_pre = 0; m_ovf = 0; end
                         else if (p_s) m_mode = 1;
            endcase
            push(cyc);
        end
    end

    bit          mon_en = 0;
    bit          seen_9_10 = 0;
    logic [15:0] prev_disp = '0;
    logic [18:0] mon_last = '0;
    logic [18:0] cur;
    exp_t        e;

    always @(negedge clk) begin
        if (mon_en) begin
            cur = {display_value, running, lap_active, overflow};
            if (cur !== mon_last) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %h at cycle %0d expected no change", cur, cyc);
                end else begin
                    e = sb.pop_front();
                    check("sb_value", 32'(cur), 32'(e.v));
                    check("sb_cycle", cyc, e.c);
                end
                for (int i = 0; i < 4; i++)
                    check("bcd_nibble_over_9", display_value[4*i +: 4] > 4'd9, 0);
                if (prev_disp == 16'h0009 && display_value == 16'h0010) seen_9_10 = 1;
                prev_disp = display_value;
                mon_last  = cur;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic btn_down(input bit s, input bit l, input bit c);
        if (s) begin b_start = 1'b1; q_start.push_back(cyc + LAT); end
        if (l) begin b_lap = 1'b1; q_lap.push_back(cyc + LAT); end
        if (c) begin b_clr = 1'b1; q_clr.push_back(cyc + LAT); end
    endtask

    task automatic btn_up();
        b_start = 1'b0; b_lap = 1'b0; b_clr = 1'b0;
    endtask

    task automatic press(input bit s, input bit l, input bit c);
        btn_down(s, l, c);
        wait_cyc(6);
        btn_up();
        wait_cyc(7);
    endtask

    task automatic glitch(input int which, input int len);
        if (which == 0) b_start = 1'b1; else if (which == 1) b_lap = 1'b1; else b_clr = 1'b1;
        wait_cyc(len);
        btn_up();
        wait_cyc(6);
    endtask

    task automatic wait_disp(input string name, input logic [15:0] target, input int budget);
        int k;
        k = 0;
        while (display_value !== target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, display_value, target);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        wait_cyc(3);
        rst_n  = 1'b1;
        mon_en = 1;
        check("rst_display", display_value, 16'h0000);
        check("rst_running", running, 0);
        check("rst_lap_active", lap_active, 0);
        check("rst_overflow", overflow, 0);

        glitch(0, 1);
        wait_cyc(6);
        check("t1_glitch_display", display_value, 16'h0000);
        check("t1_glitch_running", running, 0);

        press(1, 0, 0);
        wait_disp("t2_reach_0040", 16'h0040, 400);
        check("t2_running", running, 1);
        check("t2_seen_0009_0010", seen_9_10, 1);

        wait_disp("t3_reach_0997", 16'h0997, 5000);
        btn_down(0, 1, 0);
        wait_cyc(8);
        btn_up();
        wait_cyc(11);
        check("t3_frozen_display", display_value, 16'h0998);
        check("t3_lap_active", lap_active, 1);
        check("t3_running_in_lap", running, 1);
        btn_down(0, 1, 0);
        wait_cyc(6);
        btn_up();
        wait_cyc(1);
        check("t3_live_display", display_value, 16'h1003);
        check("t3_lap_released", lap_active, 0);
        wait_cyc(6);

        wait_disp("t4_reach_9999", 16'h9999, 40000);
        wait_disp("t4_wrap_0000", 16'h0000, 20);
        check("t4_overflow_set", overflow, 1);
        press(1, 0, 0);
        check("t4_stopped", running, 0);
        check("t4_overflow_sticky", overflow, 1);
        press(0, 0, 1);
        wait_cyc(2);
        check("t4_clr_display", display_value, 16'h0000);
        check("t4_clr_overflow", overflow, 0);
        check("t4_clr_running", running, 0);

        press(1, 0, 0);
        wait_cyc(30);
        press(1, 0, 0);
        press(1, 0, 1);
        wait_cyc(2);
        check("t5_clr_wins_display", display_value, 16'h0000);
        check("t5_clr_wins_running", running, 0);
        press(1, 0, 0);
        wait_cyc(20);
        press(0, 0, 1);
        wait_cyc(20);
        check("t5_clr_ignored_running", running, 1);
        check("t5_clr_ignored_nonzero", display_value != 16'h0000, 1);

        wait_disp("t6_reach_0123", 16'h0123, 2000);
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_display", display_value, 16'h0000);
        check("t6_async_running", running, 0);
        check("t6_async_lap_active", lap_active, 0);
        check("t6_async_overflow", overflow, 0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(20);
        check("t6_no_tick_display", display_value, 16'h0000);
        check("t6_no_tick_running", running, 0);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 4))
                0: press(1, 0, 0);
                1: press(0, 1, 0);
                2: press(0, 0, 1);
                3: glitch($urandom_range(0, 2), $urandom_range(1, 2));
                default: press(1, 0, 1);
            endcase
            wait_cyc($urandom_range(0, 40));
        end

        wait_cyc(20);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
